// File: rtl/vga_timing_programmable_if.sv
// Configuration channel for the programmable VGA timing generator.
// Latency: none, plain wires grouped for the valid/ready config offer.
// Backpressure: the slave drives cfg_ready; cfg_err reports a rejected offer.
interface vga_timing_programmable_if #(
  parameter int H_W   = 12,
  parameter int V_W   = 11,
  parameter int DIV_W = 8
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic             cfg_err;
  logic [H_W-1:0]   cfg_h_act, cfg_h_fp, cfg_h_sync, cfg_h_bp;
  logic [V_W-1:0]   cfg_v_act, cfg_v_fp, cfg_v_sync, cfg_v_bp;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_hpol, cfg_vpol;

  modport master (
    output cfg_valid, cfg_h_act, cfg_h_fp, cfg_h_sync, cfg_h_bp,
           cfg_v_act, cfg_v_fp, cfg_v_sync, cfg_v_bp, cfg_div, cfg_hpol, cfg_vpol,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_h_act, cfg_h_fp, cfg_h_sync, cfg_h_bp,
           cfg_v_act, cfg_v_fp, cfg_v_sync, cfg_v_bp, cfg_div, cfg_hpol, cfg_vpol,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/vga_timing_programmable.sv
// Programmable VGA timing generator with a shadowed config applied at frame end.
// Latency: all video outputs decode combinationally from the current position.
// Backpressure: cfg_ready drops while a config is pending and returns after it applies.
module vga_timing_programmable #(
  parameter int H_W       = 12,
  parameter int V_W       = 11,
  parameter int DIV_W     = 8,
  parameter int DEF_H_ACT = 640,
  parameter int DEF_H_FP  = 16,
  parameter int DEF_H_SYNC = 96,
  parameter int DEF_H_BP  = 48,
  parameter int DEF_V_ACT = 480,
  parameter int DEF_V_FP  = 10,
  parameter int DEF_V_SYNC = 2,
  parameter int DEF_V_BP  = 33,
  parameter int DEF_DIV   = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  vga_timing_programmable_if.slave    cfg,
  output logic                        pixel_tick,
  output logic                        h_sync,
  output logic                        v_sync,
  output logic                        de,
  output logic                        line_start,
  output logic                        frame_start,
  output logic [H_W-1:0]              h_pixel,
  output logic [V_W-1:0]              v_pixel
);
  localparam int HT_W = H_W + 2;
  localparam int VT_W = V_W + 2;
  // Largest legal totals: the position counters can reach 2^W - 1.
  localparam logic [HT_W-1:0] H_LIM = {2'b01, {H_W{1'b0}}};
  localparam logic [VT_W-1:0] V_LIM = {2'b01, {V_W{1'b0}}};

  typedef struct packed {
    logic [H_W-1:0]   h_act, h_fp, h_sync, h_bp;
    logic [V_W-1:0]   v_act, v_fp, v_sync, v_bp;
    logic [DIV_W-1:0] div;
    logic             hpol, vpol;
  } cfg_t;

  localparam cfg_t DEF_CFG = '{
    h_act: H_W'(DEF_H_ACT), h_fp: H_W'(DEF_H_FP), h_sync: H_W'(DEF_H_SYNC), h_bp: H_W'(DEF_H_BP),
    v_act: V_W'(DEF_V_ACT), v_fp: V_W'(DEF_V_FP), v_sync: V_W'(DEF_V_SYNC), v_bp: V_W'(DEF_V_BP),
    div: DIV_W'(DEF_DIV), hpol: 1'b0, vpol: 1'b0
  };

  function automatic logic [HT_W-1:0] h_total_of(cfg_t c);
    return HT_W'(c.h_act) + HT_W'(c.h_fp) + HT_W'(c.h_sync) + HT_W'(c.h_bp);
  endfunction

  function automatic logic [VT_W-1:0] v_total_of(cfg_t c);
    return VT_W'(c.v_act) + VT_W'(c.v_fp) + VT_W'(c.v_sync) + VT_W'(c.v_bp);
  endfunction

  cfg_t             act_q, act_d, pend_q, pend_d, offer;
  logic             pend_vld_q, pend_vld_d, err_q, err_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [H_W-1:0]   h_pos_q, h_pos_d;
  logic [V_W-1:0]   v_pos_q, v_pos_d;

  logic [HT_W-1:0]  h_total, h_sync_beg, h_sync_end, h_pos_x;
  logic [VT_W-1:0]  v_total, v_sync_beg, v_sync_end, v_pos_x;
  logic             tick_raw, h_wrap, v_wrap, apply, offer_ok;
  logic             h_in_act, v_in_act, h_in_sync, v_in_sync;

  assign offer = '{
    h_act: cfg.cfg_h_act, h_fp: cfg.cfg_h_fp, h_sync: cfg.cfg_h_sync, h_bp: cfg.cfg_h_bp,
    v_act: cfg.cfg_v_act, v_fp: cfg.cfg_v_fp, v_sync: cfg.cfg_v_sync, v_bp: cfg.cfg_v_bp,
    div: cfg.cfg_div, hpol: cfg.cfg_hpol, vpol: cfg.cfg_vpol
  };

  assign offer_ok = (|offer.h_act) && (|offer.v_act) && (|offer.h_sync) && (|offer.v_sync) &&
                    (h_total_of(offer) <= H_LIM) && (v_total_of(offer) <= V_LIM);

  // Divider 0 and 1 both mean one pixel per clk.
  assign tick_raw = (act_q.div <= DIV_W'(1)) || (div_q == act_q.div - DIV_W'(1));

  assign h_total    = h_total_of(act_q);
  assign v_total    = v_total_of(act_q);
  assign h_pos_x    = {2'b00, h_pos_q};
  assign v_pos_x    = {2'b00, v_pos_q};
  assign h_wrap     = (h_pos_x == h_total - HT_W'(1));
  assign v_wrap     = (v_pos_x == v_total - VT_W'(1));
  assign apply      = tick_raw && h_wrap && v_wrap && pend_vld_q;

  assign h_sync_beg = HT_W'(act_q.h_act) + HT_W'(act_q.h_fp);
  assign h_sync_end = h_sync_beg + HT_W'(act_q.h_sync);
  assign v_sync_beg = VT_W'(act_q.v_act) + VT_W'(act_q.v_fp);
  assign v_sync_end = v_sync_beg + VT_W'(act_q.v_sync);
  assign h_in_act   = (h_pos_q < act_q.h_act);
  assign v_in_act   = (v_pos_q < act_q.v_act);
  assign h_in_sync  = (h_pos_x >= h_sync_beg) && (h_pos_x < h_sync_end);
  assign v_in_sync  = (v_pos_x >= v_sync_beg) && (v_pos_x < v_sync_end);

  // Next state: divider, raster position, config handshake and frame-aligned apply.
  always_comb begin
    act_d      = act_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    err_d      = 1'b0;
    div_d      = tick_raw ? '0 : div_q + DIV_W'(1);
    h_pos_d    = h_pos_q;
    v_pos_d    = v_pos_q;
    if (tick_raw) begin
      if (h_wrap) begin
        h_pos_d = '0;
        v_pos_d = v_wrap ? '0 : v_pos_q + V_W'(1);
      end else begin
        h_pos_d = h_pos_q + H_W'(1);
      end
    end
    // Offers are only looked at while nothing is pending, so accept and apply never coincide.
    if (cfg.cfg_valid && !pend_vld_q) begin
      if (offer_ok) begin
        pend_d     = offer;
        pend_vld_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
    if (apply) begin
      act_d      = pend_q;
      pend_vld_d = 1'b0;
      div_d      = '0;
    end
  end

  // Synchronous active-low reset restores default timing and discards any pending config.
  always_ff @(posedge clk) begin
    if (!reset) begin
      act_q      <= DEF_CFG;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      err_q      <= 1'b0;
      div_q      <= '0;
      h_pos_q    <= '0;
      v_pos_q    <= '0;
    end else begin
      act_q      <= act_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      err_q      <= err_d;
      div_q      <= div_d;
      h_pos_q    <= h_pos_d;
      v_pos_q    <= v_pos_d;
    end
  end

  assign cfg.cfg_ready = ~pend_vld_q;
  assign cfg.cfg_err   = err_q;

  // While reset is held the outputs sit at an idle, blank-free level.
  assign pixel_tick  = reset & tick_raw;
  assign line_start  = pixel_tick && (h_pos_q == '0);
  assign frame_start = line_start && (v_pos_q == '0);
  assign h_sync      = reset ? (h_in_sync ? act_q.hpol : ~act_q.hpol) : 1'b1;
  assign v_sync      = reset ? (v_in_sync ? act_q.vpol : ~act_q.vpol) : 1'b1;
  assign de          = reset ? (h_in_act && v_in_act) : 1'b1;
  assign h_pixel     = (reset && h_in_act) ? h_pos_q : '0;
  assign v_pixel     = (reset && v_in_act) ? v_pos_q : '0;
endmodule

// File: tb/tb_vga_timing_programmable.sv
// Bench for vga_timing_programmable: a default-parameter instance and a narrow instance
// with small reset timing, both compared every cycle against a time-based raster model.
`timescale 1ns/1ps
module tb_vga_timing_programmable;
  typedef struct {
    int h_act, h_fp, h_sync, h_bp, v_act, v_fp, v_sync, v_bp, div;
    bit hpol, vpol;
  } mcfg_t;
  typedef struct packed {
    logic tick, hs, vs, de, ls, fs, rdy, err;
    logic [11:0] hp;
    logic [10:0] vp;
  } obs_t;
  typedef struct {
    mcfg_t c;
    bit    ok;
    int    frame_clk;
    string name;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  vga_timing_programmable_if #(.H_W(12), .V_W(11), .DIV_W(8)) if0 ();
  vga_timing_programmable_if #(.H_W(6), .V_W(5), .DIV_W(4)) if1 ();

  logic tk0, hs0, vs0, de0, ls0, fs0, tk1, hs1, vs1, de1, ls1, fs1;
  logic [11:0] hp0; logic [10:0] vp0;
  logic [5:0]  hp1; logic [4:0]  vp1;

  vga_timing_programmable dut_def (
    .clk(clk), .reset(reset), .cfg(if0),
    .pixel_tick(tk0), .h_sync(hs0), .v_sync(vs0), .de(de0),
    .line_start(ls0), .frame_start(fs0), .h_pixel(hp0), .v_pixel(vp0)
  );

  vga_timing_programmable #(
    .H_W(6), .V_W(5), .DIV_W(4),
    .DEF_H_ACT(8), .DEF_H_FP(2), .DEF_H_SYNC(3), .DEF_H_BP(3),
    .DEF_V_ACT(4), .DEF_V_FP(1), .DEF_V_SYNC(1), .DEF_V_BP(2), .DEF_DIV(1)
  ) dut (
    .clk(clk), .reset(reset), .cfg(if1),
    .pixel_tick(tk1), .h_sync(hs1), .v_sync(vs1), .de(de1),
    .line_start(ls1), .frame_start(fs1), .h_pixel(hp1), .v_pixel(vp1)
  );

  int    checks = 0, errors = 0, cyc = 0;
  bit    chk_en = 0;
  mcfg_t m_act[2], m_pend[2], cur_off;
  bit    m_pv[2], m_err[2];
  int    m_t[2];
  logic  s_hs0, s_ls0, s_fs1, s_rdy1;
  vec_t  vecs[11];

  function automatic mcfg_t defc(int i);
    mcfg_t c;
    if (i == 0) c = '{640, 16, 96, 48, 480, 10, 2, 33, 1, 0, 0};
    else        c = '{8, 2, 3, 3, 4, 1, 1, 2, 1, 0, 0};
    return c;
  endfunction

  function automatic int htot(mcfg_t c); return c.h_act + c.h_fp + c.h_sync + c.h_bp; endfunction
  function automatic int vtot(mcfg_t c); return c.v_act + c.v_fp + c.v_sync + c.v_bp; endfunction
  function automatic int per(mcfg_t c);  return (c.div <= 1) ? 1 : c.div; endfunction

  function automatic bit cfg_ok(mcfg_t c, int i);
    int hw, vw;
    hw = (i == 0) ? 12 : 6;
    vw = (i == 0) ? 11 : 5;
    return c.h_act != 0 && c.v_act != 0 && c.h_sync != 0 && c.v_sync != 0 &&
           htot(c) <= (1 << hw) && vtot(c) <= (1 << vw);
  endfunction

  // Raster position follows from elapsed clocks since the last reset/apply.
  function automatic obs_t expect_obs(int i);
    obs_t o; mcfg_t c; int p, ht, vt, k, h, v; bit tk;
    c = m_act[i]; p = per(c); ht = htot(c); vt = vtot(c);
    k = (m_t[i] / p) % (ht * vt); h = k % ht; v = k / ht;
    tk = (m_t[i] % p) == p - 1;
    o = '0;
    o.rdy = !m_pv[i];
    o.err = m_err[i];
    if (reset !== 1'b1) begin
      o.hs = 1'b1; o.vs = 1'b1; o.de = 1'b1;
      return o;
    end
    o.tick = tk;
    o.hs = (h >= c.h_act + c.h_fp && h < c.h_act + c.h_fp + c.h_sync) ? c.hpol : !c.hpol;
    o.vs = (v >= c.v_act + c.v_fp && v < c.v_act + c.v_fp + c.v_sync) ? c.vpol : !c.vpol;
    o.de = (h < c.h_act) && (v < c.v_act);
    o.hp = (h < c.h_act) ? 12'(h) : 12'd0;
    o.vp = (v < c.v_act) ? 11'(v) : 11'd0;
    o.ls = tk && h == 0;
    o.fs = o.ls && v == 0;
    return o;
  endfunction

  task automatic model_update(int i, logic vld, mcfg_t off);
    mcfg_t c; int p, ht, vt, k; bit tk, fe, pv, e;
    if (reset !== 1'b1) begin
      m_act[i] = defc(i); m_pv[i] = 0; m_err[i] = 0; m_t[i] = 0;
      return;
    end
    c = m_act[i]; p = per(c); ht = htot(c); vt = vtot(c);
    k = (m_t[i] / p) % (ht * vt);
    tk = (m_t[i] % p) == p - 1;
    fe = tk && (k == ht * vt - 1);
    pv = m_pv[i]; e = 0;
    if (vld === 1'b1 && !m_pv[i]) begin
      if (cfg_ok(off, i)) begin m_pend[i] = off; pv = 1; end
      else e = 1;
    end
    if (fe && m_pv[i]) begin m_act[i] = m_pend[i]; pv = 0; m_t[i] = 0; end
    else m_t[i]++;
    m_pv[i] = pv; m_err[i] = e;
  endtask

  task automatic cmp(string nm, obs_t act, obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic chk_int(string nm, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  task automatic chk_bit(string nm, logic got, logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%b want=%b", nm, got, want);
    end
  endtask

  task automatic drive_off(mcfg_t c, bit vld);
    cur_off = c;
    if1.cfg_valid  = vld;
    if1.cfg_h_act  = 6'(c.h_act);  if1.cfg_h_fp  = 6'(c.h_fp);
    if1.cfg_h_sync = 6'(c.h_sync); if1.cfg_h_bp  = 6'(c.h_bp);
    if1.cfg_v_act  = 5'(c.v_act);  if1.cfg_v_fp  = 5'(c.v_fp);
    if1.cfg_v_sync = 5'(c.v_sync); if1.cfg_v_bp  = 5'(c.v_bp);
    if1.cfg_div    = 4'(c.div);
    if1.cfg_hpol   = c.hpol;       if1.cfg_vpol  = c.vpol;
  endtask

  // One clock: compare at negedge, advance the model with the inputs seen at posedge.
  task automatic step();
    obs_t a0, a1;
    @(negedge clk);
    a0 = {tk0, hs0, vs0, de0, ls0, fs0, if0.cfg_ready, if0.cfg_err, hp0, vp0};
    a1 = {tk1, hs1, vs1, de1, ls1, fs1, if1.cfg_ready, if1.cfg_err, 6'b0, hp1, 6'b0, vp1};
    s_hs0 = hs0; s_ls0 = ls0; s_fs1 = fs1; s_rdy1 = if1.cfg_ready;
    if (chk_en) begin
      cmp("dut_def", a0, expect_obs(0));
      cmp("dut", a1, expect_obs(1));
    end
    @(posedge clk);
    model_update(0, 1'b0, cur_off);
    model_update(1, if1.cfg_valid, cur_off);
    cyc++;
    #1;
  endtask

  task automatic wait_ready(string nm);
    int n;
    n = 0;
    while (if1.cfg_ready !== 1'b1 && n < 6000) begin step(); n++; end
    chk_bit(nm, if1.cfg_ready, 1'b1);
  endtask

  task automatic frame_period(output int clks);
    int n, c0;
    n = 0;
    do begin step(); n++; end while (s_fs1 !== 1'b1 && n < 6000);
    c0 = cyc;
    n = 0;
    do begin step(); n++; end while (s_fs1 !== 1'b1 && n < 6000);
    clks = cyc - c0;
  endtask

  // Call right after reset release: first step is raster cycle 0 of the 800x525 default.
  task automatic def_line_check(string tag);
    int low_n, first_low, ls_n;
    low_n = 0; first_low = -1; ls_n = 0;
    for (int c = 0; c < 1600; c++) begin
      step();
      if (s_hs0 === 1'b0) begin
        if (first_low < 0) first_low = c;
        low_n++;
      end
      if (s_ls0 === 1'b1) ls_n++;
    end
    chk_int({tag, "_hs_first"}, first_low, 656);
    chk_int({tag, "_hs_len"}, low_n, 192);
    chk_int({tag, "_lines"}, ls_n, 2);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    mcfg_t z, r;
    int fp;

    vecs[0]  = '{'{4, 1, 2, 1, 3, 1, 1, 1, 1, 0, 0}, 1, 48, "h4v3"};
    vecs[1]  = '{'{0, 1, 2, 1, 3, 1, 1, 1, 1, 0, 0}, 0, 48, "hact0"};
    vecs[2]  = '{'{10, 2, 3, 5, 5, 1, 2, 2, 4, 0, 0}, 1, 800, "div4"};
    vecs[3]  = '{'{10, 2, 3, 5, 5, 1, 0, 2, 4, 0, 0}, 0, 800, "vsync0"};
    vecs[4]  = '{'{6, 2, 2, 2, 4, 1, 1, 1, 2, 1, 1}, 1, 168, "pol11"};
    vecs[5]  = '{'{40, 10, 10, 5, 4, 1, 1, 1, 1, 0, 0}, 0, 168, "htot65"};
    vecs[6]  = '{'{4, 1, 0, 1, 3, 1, 1, 1, 1, 0, 0}, 0, 168, "hsync0"};
    vecs[7]  = '{'{4, 1, 2, 1, 0, 1, 1, 1, 1, 0, 0}, 0, 168, "vact0"};
    vecs[8]  = '{'{5, 0, 1, 0, 2, 0, 1, 0, 3, 1, 0}, 1, 54, "nofpbp"};
    vecs[9]  = '{'{40, 10, 10, 4, 20, 4, 4, 4, 0, 0, 1}, 1, 2048, "max_div0"};
    vecs[10] = '{'{4, 1, 2, 1, 20, 4, 4, 5, 1, 0, 0}, 0, 2048, "vtot33"};

    z = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    m_act[0] = defc(0); m_act[1] = defc(1);
    if0.cfg_valid = 1'b0;
    if0.cfg_h_act = '0; if0.cfg_h_fp = '0; if0.cfg_h_sync = '0; if0.cfg_h_bp = '0;
    if0.cfg_v_act = '0; if0.cfg_v_fp = '0; if0.cfg_v_sync = '0; if0.cfg_v_bp = '0;
    if0.cfg_div = '0; if0.cfg_hpol = 1'b0; if0.cfg_vpol = 1'b0;
    drive_off(z, 1'b0);

    // Reset held: outputs at idle level once the first reset edge has passed.
    reset = 1'b0;
    step(); step();
    chk_en = 1;
    step(); step();
    reset = 1'b1;
    def_line_check("def");

    // Table: offer, check accept/reject, then measure the frame period that results.
    foreach (vecs[j]) begin
      wait_ready({vecs[j].name, "_rdy_pre"});
      drive_off(vecs[j].c, 1'b1);
      step();
      drive_off(vecs[j].c, 1'b0);
      chk_bit({vecs[j].name, "_err"}, if1.cfg_err, !vecs[j].ok);
      chk_bit({vecs[j].name, "_rdy"}, if1.cfg_ready, !vecs[j].ok);
      if (vecs[j].ok) begin
        wait_ready({vecs[j].name, "_apply"});
      end else begin
        step();
        chk_bit({vecs[j].name, "_err_pulse"}, if1.cfg_err, 1'b0);
      end
      frame_period(fp);
      chk_int({vecs[j].name, "_frame"}, fp, vecs[j].frame_clk);
    end

    // Valid held through the pending window: ignored while not ready, taken the cycle after apply.
    wait_ready("hold_rdy_pre");
    drive_off(vecs[0].c, 1'b1);
    step();
    drive_off(vecs[8].c, 1'b1);
    begin
      int n;
      n = 0;
      do begin step(); n++; end while (s_rdy1 !== 1'b1 && n < 6000);
    end
    chk_bit("hold_apply", s_rdy1, 1'b1);
    step();
    chk_bit("hold_accept", s_rdy1, 1'b0);
    chk_bit("hold_err", if1.cfg_err, 1'b0);
    drive_off(vecs[8].c, 1'b0);
    wait_ready("hold_rdy_post");
    frame_period(fp);
    chk_int("hold_frame", fp, 54);

    // Reset mid-frame with a pending config: pending is discarded, defaults return.
    wait_ready("rst_rdy_pre");
    drive_off(vecs[4].c, 1'b1);
    step();
    drive_off(vecs[4].c, 1'b0);
    repeat (5) step();
    chk_bit("rst_pending", if1.cfg_ready, 1'b0);
    reset = 1'b0;
    step(); step();
    reset = 1'b1;
    chk_bit("rst_ready", if1.cfg_ready, 1'b1);
    def_line_check("rst");
    frame_period(fp);
    chk_int("rst_small_frame", fp, 128);

    // Random offers at random times with random field values, including illegal ones.
    for (int n = 0; n < 6000; n++) begin
      r.h_act = $urandom_range(0, 8);  r.h_fp = $urandom_range(0, 3);
      r.h_sync = $urandom_range(0, 3); r.h_bp = $urandom_range(0, 3);
      r.v_act = $urandom_range(0, 5);  r.v_fp = $urandom_range(0, 2);
      r.v_sync = $urandom_range(0, 2); r.v_bp = $urandom_range(0, 2);
      r.div = $urandom_range(0, 4);
      r.hpol = 1'($urandom_range(0, 1)); r.vpol = 1'($urandom_range(0, 1));
      drive_off(r, $urandom_range(0, 7) == 0);
      step();
    end
    drive_off(z, 1'b0);
    repeat (4) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vga_timing_programmable.md
VGA_TIMING_PROGRAMMABLE -- requirements
Module: vga_timing_programmable

Interface
REQ-001 SHALL have parameter H_W, default 12: width of horizontal position counter and horizontal config fields.
REQ-002 SHALL have parameter V_W, default 11: width of vertical position counter and vertical config fields.
REQ-003 SHALL have parameter DIV_W, default 8: width of pixel clock divider.
REQ-004 SHALL have parameters DEF_H_ACT/FP/SYNC/BP = 640/16/96/48, DEF_V_ACT/FP/SYNC/BP = 480/10/2/33 and DEF_DIV = 1: reset timing.
REQ-005 SHALL have port clk, input, 1: clock.
REQ-006 SHALL have port reset, input, 1: synchronous, active-low reset.
REQ-007 SHALL have port cfg_valid, input, 1: new configuration offered.
REQ-008 SHALL have port cfg_ready, output, 1: configuration can be accepted.
REQ-009 SHALL have ports cfg_h_act, cfg_h_fp, cfg_h_sync, cfg_h_bp, input, H_W each: horizontal timing in pixel ticks.
REQ-010 SHALL have ports cfg_v_act, cfg_v_fp, cfg_v_sync, cfg_v_bp, input, V_W each: vertical timing in lines.
REQ-011 SHALL have port cfg_div, input, DIV_W: clk cycles per pixel tick.
REQ-012 SHALL have ports cfg_hpol and cfg_vpol, input, 1 each: sync asserted level (1 = active-high).
REQ-013 SHALL have port cfg_err, output, 1: one-cycle pulse when an offered config is rejected.
REQ-014 SHALL have ports pixel_tick, h_sync, v_sync, de, line_start and frame_start, output, 1 each.
REQ-015 SHALL have ports h_pixel, output, H_W, and v_pixel, output, V_W: current active pixel coordinates.

Function
REQ-016 SHALL assert pixel_tick for one clk when the divider counter equals div-1, then wrap it to 0; div 0 or 1 SHALL give pixel_tick every cycle.
REQ-017 SHALL advance h_pos only on pixel_tick, wrapping at h_total-1 (h_total = act+fp+sync+bp, computed H_W+2 bits wide); on wrap v_pos SHALL increment, wrapping at v_total-1.
REQ-018 SHALL drive h_pixel = h_pos when h_pos < h_act, else 0; v_pixel likewise with v_act.
REQ-019 SHALL drive de = (h_pos < h_act) && (v_pos < v_act).
REQ-020 SHALL drive h_sync = hpol when act+fp <= h_pos < act+fp+sync, else !hpol; v_sync likewise with vpol.
REQ-021 SHALL drive line_start = pixel_tick && h_pos==0, and frame_start = line_start && v_pos==0.
REQ-022 SHALL decode all outputs combinationally from the position registers and the active config; no extra latency.
REQ-023 SHALL accept a config on cfg_valid && cfg_ready into a pending shadow register and drop cfg_ready the next cycle.
REQ-024 SHALL reject, without storing, a config with h_act, v_act, h_sync or v_sync equal to 0, or h_total > 2^H_W, or v_total > 2^V_W; rejection SHALL pulse cfg_err for 1 clk and keep cfg_ready high.
REQ-025 SHALL copy the pending config to active on the pixel_tick at which h_pos==h_total-1 && v_pos==v_total-1; the next position 0,0 SHALL use the new timing and the new divider.
REQ-026 SHALL restart the divider counter at 0 on the apply cycle.
REQ-027 SHALL raise cfg_ready the cycle after apply.
REQ-028 SHALL ignore cfg_valid while cfg_ready is low; cfg_valid coincident with apply SHALL not be accepted in that cycle.

Reset
REQ-029 SHALL on reset low load active config from DEF_* parameters with hpol = vpol = 0, clear the pending config, clear divider, h_pos and v_pos, and set cfg_ready = 1 and cfg_err = 0.
REQ-030 SHALL have, during reset: h_sync = v_sync = 1, de = 1, h_pixel = v_pixel = 0, line_start = frame_start = pixel_tick = 0.
REQ-031 SHALL on reset mid-frame discard any pending config.

Verification
REQ-032 SHALL cover: defaults, div 1 -> h_sync low at h_pos 656..751, line period 800 clk, frame_start every 420000 clk.
REQ-033 SHALL cover: config div=4 -> after apply, pixel_tick every 4 clk and h_pixel stable for 4 clk.
REQ-034 SHALL cover: mid-frame config h 4/1/2/1, v 3/1/1/1 -> cfg_ready low until frame end, then frame_start every 8*6 = 48 ticks.
REQ-035 SHALL cover: config with h_act=0 -> cfg_err 1-clk pulse, cfg_ready stays 1, timing unchanged.
REQ-036 SHALL cover: hpol=1, vpol=1 -> h_sync and v_sync high only inside their sync windows.
REQ-037 SHALL cover: reset mid-frame with pending config -> h_pos = v_pos = 0, 640x480 defaults, pending config never applied.
